// File: rtl/sample_frame_builder.sv
// sample_frame_builder
//
// Turns the L1A-FIFO / sample-RAM read stream of the transfer-samples
// sequencer into framed 16-bit words:
//   {A,l1a} {B,l1a} {0,sample} x N {E,xor of samples} {F,word count}
//
// The sequencer's read strobes are delayed by RD_LAT so that each capture
// lines up with the cycle the memory data is valid. L1A words wait in a
// two-entry pending buffer until the frame FSM is ready to turn them into
// headers. The FSM state, word count, checksum, frame counter and error flag
// are held in three copies and majority-voted every cycle.
//
// Ports
//   CLK, RST         clock, asynchronous active-high reset
//   L1A_RD_EN        L1A FIFO read strobe (L1A_DATA valid RD_LAT later)
//   L1A_DATA[11:0]   L1A FIFO read data
//   RDENA            sample RAM read strobe (SMP_DATA valid RD_LAT later)
//   SMP_DATA[11:0]   sample RAM read data
//   DOUT[15:0]       framed output word, holds its value while DOUT_VLD=0
//   DOUT_VLD         DOUT carries a new word
//   FRM_DONE         pulse with the last trailer word of a frame
//   FRM_CNT[7:0]     completed frames, wraps
//   ERR              sticky protocol error (orphan data, overflow, truncation)
//   XSTATE[2:0]      voted FSM state
//
// Handshake: there is no back-pressure. A capture enable (hcap/dcap) being
// high in a cycle means the matching data input is valid in that cycle and
// is consumed there; DOUT is valid in exactly the cycles DOUT_VLD is high.
module sample_frame_builder #(
    parameter int RD_LAT          = 1,
    parameter int WORDS_PER_FRAME = 96
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        L1A_RD_EN,
    input  logic [11:0] L1A_DATA,
    input  logic        RDENA,
    input  logic [11:0] SMP_DATA,
    output logic [15:0] DOUT,
    output logic        DOUT_VLD,
    output logic        FRM_DONE,
    output logic [7:0]  FRM_CNT,
    output logic        ERR,
    output logic [2:0]  XSTATE
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_TRL1 = 3'd3,
        S_TRL2 = 3'd4
    } state_e;

    localparam logic [11:0] WPF = 12'(WORDS_PER_FRAME);

    // ------------------------------------------------------------------
    // Strobe delay lines: bit RD_LAT-1 is high in the cycle the read data
    // belonging to the strobe is on the memory output.
    // ------------------------------------------------------------------
    logic [RD_LAT-1:0] hdl_q;
    logic [RD_LAT-1:0] ddl_q;
    logic              hcap;
    logic              dcap;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hdl_q <= '0;
            ddl_q <= '0;
        end else begin
            hdl_q[0] <= L1A_RD_EN;
            ddl_q[0] <= RDENA;
            for (int i = 1; i < RD_LAT; i++) begin
                hdl_q[i] <= hdl_q[i-1];
                ddl_q[i] <= ddl_q[i-1];
            end
        end
    end

    assign hcap = hdl_q[RD_LAT-1];
    assign dcap = ddl_q[RD_LAT-1];

    // ------------------------------------------------------------------
    // Pending header buffer. Entry 0 is the oldest word. A word arriving
    // while both entries are occupied is dropped, even if the FSM pops in
    // the same cycle.
    // ------------------------------------------------------------------
    logic [11:0] pend0_q;
    logic [11:0] pend1_q;
    logic [1:0]  pend_cnt_q;
    logic        pend_full;
    logic        push;
    logic        pop;

    assign pend_full = (pend_cnt_q == 2'd2);
    assign push      = hcap && !pend_full;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend0_q    <= '0;
            pend1_q    <= '0;
            pend_cnt_q <= '0;
        end else begin
            case ({push, pop})
                2'b01: begin
                    pend0_q    <= pend1_q;
                    pend_cnt_q <= pend_cnt_q - 2'd1;
                end
                2'b10: begin
                    if (pend_cnt_q == 2'd0) pend0_q <= L1A_DATA;
                    else                    pend1_q <= L1A_DATA;
                    pend_cnt_q <= pend_cnt_q + 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry: it leaves, the new one
                    // takes its place.
                    pend0_q <= L1A_DATA;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Triplicated control state and its majority vote
    // ------------------------------------------------------------------
    logic [2:0][2:0]  st_q;
    logic [2:0][11:0] wc_q;
    logic [2:0][11:0] chk_q;
    logic [2:0][7:0]  fcnt_q;
    logic [2:0]       err_q;

    logic [2:0]  st_v;
    logic [11:0] wc_v;
    logic [11:0] chk_v;
    logic [7:0]  fcnt_v;
    logic        err_v;

    assign st_v   = (st_q[0]   & st_q[1])   | (st_q[0]   & st_q[2])   | (st_q[1]   & st_q[2]);
    assign wc_v   = (wc_q[0]   & wc_q[1])   | (wc_q[0]   & wc_q[2])   | (wc_q[1]   & wc_q[2]);
    assign chk_v  = (chk_q[0]  & chk_q[1])  | (chk_q[0]  & chk_q[2])  | (chk_q[1]  & chk_q[2]);
    assign fcnt_v = (fcnt_q[0] & fcnt_q[1]) | (fcnt_q[0] & fcnt_q[2]) | (fcnt_q[1] & fcnt_q[2]);
    assign err_v  = (err_q[0]  & err_q[1])  | (err_q[0]  & err_q[2])  | (err_q[1]  & err_q[2]);

    state_e      st_d;
    logic [11:0] wc_d;
    logic [11:0] chk_d;
    logic [7:0]  fcnt_d;
    logic        err_d;
    logic [11:0] wc_inc;

    logic [15:0] dout_q;
    logic        vld_q;
    logic        done_q;
    logic [15:0] dout_d;
    logic        vld_d;
    logic        done_d;

    assign wc_inc = wc_v + 12'd1;

    // Every copy loads the same value computed from the voted state, so a
    // single upset copy is outvoted now and overwritten at the next edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_q   <= '0;
            wc_q   <= '0;
            chk_q  <= '0;
            fcnt_q <= '0;
            err_q  <= '0;
        end else begin
            st_q   <= {st_d, st_d, st_d};
            wc_q   <= {wc_d, wc_d, wc_d};
            chk_q  <= {chk_d, chk_d, chk_d};
            fcnt_q <= {fcnt_d, fcnt_d, fcnt_d};
            err_q  <= {err_d, err_d, err_d};
        end
    end

    always_comb begin
        st_d   = S_IDLE;
        wc_d   = wc_v;
        chk_d  = chk_v;
        fcnt_d = fcnt_v;
        err_d  = err_v | (hcap && pend_full);
        pop    = 1'b0;
        dout_d = dout_q;
        vld_d  = 1'b0;
        done_d = 1'b0;

        case (st_v)
            S_IDLE: begin
                if (dcap) err_d = 1'b1;
                if (pend_cnt_q != 2'd0) begin
                    pop    = 1'b1;
                    dout_d = {4'hA, pend0_q};
                    vld_d  = 1'b1;
                    wc_d   = '0;
                    chk_d  = '0;
                    st_d   = S_HDR;
                end
            end
            S_HDR: begin
                st_d = S_HDR;
                if (dcap) err_d = 1'b1;
                if (pend_cnt_q != 2'd0) begin
                    pop    = 1'b1;
                    dout_d = {4'hB, pend0_q};
                    vld_d  = 1'b1;
                    st_d   = S_DATA;
                end
            end
            S_DATA: begin
                st_d = S_DATA;
                if (dcap) begin
                    dout_d = {4'h0, SMP_DATA};
                    vld_d  = 1'b1;
                    wc_d   = wc_inc;
                    chk_d  = chk_v ^ SMP_DATA;
                end
                if (dcap && (wc_inc == WPF)) begin
                    st_d = S_TRL1;
                end else if (pend_cnt_q != 2'd0) begin
                    // A new header arrived before the frame filled up: close
                    // this frame short and leave the header for the next one.
                    err_d = 1'b1;
                    st_d  = S_TRL1;
                end
            end
            S_TRL1: begin
                if (dcap) err_d = 1'b1;
                dout_d = {4'hE, chk_v};
                vld_d  = 1'b1;
                st_d   = S_TRL2;
            end
            S_TRL2: begin
                if (dcap) err_d = 1'b1;
                dout_d = {4'hF, wc_v};
                vld_d  = 1'b1;
                done_d = 1'b1;
                fcnt_d = fcnt_v + 8'd1;
                st_d   = S_IDLE;
            end
            default: st_d = S_IDLE;  // unused encodings: silent return to idle
        endcase
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
            vld_q  <= vld_d;
            done_q <= done_d;
        end
    end

    assign DOUT     = dout_q;
    assign DOUT_VLD = vld_q;
    assign FRM_DONE = done_q;
    assign FRM_CNT  = fcnt_v;
    assign ERR      = err_v;
    assign XSTATE   = st_v;

endmodule

// File: doc/sample_frame_builder.md
# sample_frame_builder

Formats the L1A-FIFO and sample-RAM read stream produced by the transfer-samples sequencer into framed 16-bit output words. It sits directly downstream of that sequencer. It observes the sequencer's read strobes L1A_RD_EN and RDENA, and realigns the FIFO/RAM read data by the memory latency. Each frame it emits is a two-word header, WORDS_PER_FRAME data words, and a two-word trailer carrying a checksum and a word count. Control state is triplicated with majority voting, matching the sequencer's SEU hardening.

## Interface
- RD_LAT, 1: read latency in cycles from a strobe to valid L1A_DATA / SMP_DATA; range 1..4.
- WORDS_PER_FRAME, 96: data words per frame (6 chips × 16 channels); range 1..4095.

- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- L1A_RD_EN  in  1  L1A FIFO read strobe from the sequencer.
- L1A_DATA  in  12  L1A FIFO output; valid RD_LAT cycles after each L1A_RD_EN.
- RDENA  in  1  sample RAM read strobe from the sequencer.
- SMP_DATA  in  12  sample RAM output; valid RD_LAT cycles after each RDENA.
- DOUT  out  16  framed output word.
- DOUT_VLD  out  1  DOUT is valid this cycle.
- FRM_DONE  out  1  one-cycle pulse coincident with the last trailer word.
- FRM_CNT  out  8  completed-frame counter; wraps 255→0.
- ERR  out  1  sticky protocol error flag; cleared only by RST.
- XSTATE  out  3  voted state, for debug.

## Operation
- Capture enables:
  - hcap = L1A_RD_EN delayed RD_LAT cycles.
  - dcap = RDENA delayed RD_LAT cycles.
  - Delay lines are reset to 0.
- Pending header buffer: 2-entry FIFO of 12-bit L1A words.
  - Every hcap pushes L1A_DATA into it.
  - A push when full drops the word and sets ERR.
- Word formats:
  - header 1 = {4'hA, L1A word}; header 2 = {4'hB, L1A word}.
  - data = {4'h0, SMP_DATA}.
  - trailer 1 = {4'hE, chk}, where chk = XOR of all data samples in the frame.
  - trailer 2 = {4'hF, wc}, where wc = data words emitted in the frame.
- States: IDLE=0, HDR=1, DATA=2, TRL1=3, TRL2=4.
  - IDLE, pending buffer non-empty: pop, emit header 1, clear wc and chk, go to HDR.
  - HDR, pending buffer non-empty: pop, emit header 2, go to DATA.
  - DATA, dcap: emit data word, wc+1, chk ^= sample.
    - When wc reaches WORDS_PER_FRAME, go to TRL1.
  - DATA, pending buffer non-empty before the frame is complete (truncated frame): set ERR, go to TRL1.
    - The pending header is kept for the next frame.
  - TRL1: emit trailer 1, go to TRL2.
  - TRL2: emit trailer 2, pulse FRM_DONE, FRM_CNT+1, go to IDLE.
- dcap in IDLE, HDR, TRL1 or TRL2: sample dropped, ERR set.
- dcap in DATA, same cycle as completion: the completing word is emitted; there is no extra word.
- hcap in any state: buffered only. Headers are never emitted before the previous frame's trailer.
- Encodings 5–7 are illegal and go to IDLE. This is an ERR-free recovery.
- TMR:
  - Triplicated with 2-of-3 majority vote: state, wc, chk, FRM_CNT, ERR.
  - Each copy's next value is computed from voted values.
  - All outputs are driven from voted values.

## Timing
- Reset values:
  - DOUT=0, DOUT_VLD=0, FRM_DONE=0, FRM_CNT=0, ERR=0, XSTATE=0.
  - Pending buffer empty, wc=0, chk=0.
- Outputs are registered. A word whose trigger condition holds in cycle t appears on DOUT/DOUT_VLD in cycle t+1.
- Header latency:
  - Header 1 appears RD_LAT+2 cycles after L1A_RD_EN: RD_LAT cycles to capture, 1 cycle in the pending buffer, 1 output register.
  - Consecutive header words are emitted on consecutive cycles when available.
- Data latency: RD_LAT+1 cycles from RDENA to DOUT_VLD, one word per cycle, back-to-back.
- Trailer words follow the last data word on the two immediately following cycles.
- Minimum gap between frames: 0 idle cycles if a header is pending.
- DOUT holds its last value when DOUT_VLD=0.
- RST mid-frame: all state is cleared immediately and the partial frame is abandoned without a trailer.

## Test plan
- **Nominal frame (RD_LAT=1, WORDS_PER_FRAME=96):**
  - Stimulus: 2 L1A strobes (L1A_DATA 0x123, 0x045), then 96 RDENA with samples 0..95.
  - Required: A123, B045, 0000..005F, E000 (chk of 0..95 = 0x000), F060.
  - FRM_DONE pulses with F060; FRM_CNT=1; ERR=0.
- **Back-to-back frames:**
  - Stimulus: header strobes for frame 2 issued during frame 1's last data words.
  - Required: frame 2 header words start the cycle after F060; no ERR.
- **Truncated frame:**
  - Stimulus: new headers after 10 data words.
  - Required: E(chk of 10 samples), F00A, then the new header; ERR=1.
- **Orphan data:**
  - Stimulus: RDENA with no prior header.
  - Required: no DOUT_VLD, ERR=1.
  - After RST: ERR=0.
- **Pending overflow:**
  - Stimulus: 3 L1A strobes with no frame drained.
  - Required: the third word is dropped; ERR=1.
- **Upset and reset:**
  - Force one copy of state or wc mid-frame: output identical to the undisturbed run.
  - Assert RST at data word 50: all outputs 0 the same cycle; the next frame is clean.
